// File: rtl/cache_fill_fsm.sv
// Cache miss handler: fetches one WORDS x 16-bit block, streams each word into the data array, then writes the tag.
// Reads issue on consecutive cycles from the cycle after the miss; returned words are accepted whenever valid.
module cache_fill_fsm #(
  parameter int WORDS = 8,
  parameter int AW    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          miss_detected,
  input  logic [AW-1:0] miss_address,
  input  logic          memory_data_valid,
  input  logic [15:0]   memory_data,
  output logic          fsm_busy,
  output logic          mem_read_req,
  output logic [AW-1:0] memory_address,
  output logic          write_data_array,
  output logic [AW-1:0] fill_address,
  output logic [15:0]   fill_data,
  output logic          write_tag_array
);

  // Counters are one bit wider than a word index, which also equals the byte-offset width of a block.
  localparam int CW = $clog2(WORDS) + 1;

  typedef enum logic [1:0] {IDLE, FILL, TAG} state_e;

  state_e           state_q, state_d;
  logic [AW-CW-1:0] blk_q, blk_d;
  logic [CW-1:0]    issue_cnt_q, issue_cnt_d;
  logic [CW-1:0]    recv_cnt_q, recv_cnt_d;

  logic unused_miss_offset;
  assign unused_miss_offset = ^miss_address[CW-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      blk_q       <= '0;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      blk_q       <= blk_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    blk_d       = blk_q;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (miss_detected) begin
          state_d     = FILL;
          blk_d       = miss_address[AW-1:CW];
          issue_cnt_d = '0;
          recv_cnt_d  = '0;
        end
      end
      FILL: begin
        if (mem_read_req) issue_cnt_d = issue_cnt_q + CW'(1);
        if (write_data_array) begin
          recv_cnt_d = recv_cnt_q + CW'(1);
          if (recv_cnt_q == CW'(WORDS - 1)) state_d = TAG;
        end
      end
      TAG:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Addresses are built from the block number and the word index, so they never leave the block.
  always_comb begin
    fsm_busy         = (state_q != IDLE);
    mem_read_req     = (state_q == FILL) && (issue_cnt_q < CW'(WORDS));
    write_data_array = (state_q == FILL) && memory_data_valid;
    write_tag_array  = (state_q == TAG);
    memory_address   = {blk_q, issue_cnt_q[CW-2:0], 1'b0};
    fill_address     = {blk_q, recv_cnt_q[CW-2:0], 1'b0};
    fill_data        = memory_data;
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Bench for cache_fill_fsm: a behavioural 4-cycle memory feeds the DUT, and each scenario
// compares the observed read/write/tag streams against addresses and timings worked out from the block rules.
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst_n, miss_detected, memory_data_valid;
  logic [15:0] miss_address, memory_data;
  logic        fsm_busy, mem_read_req, write_data_array, write_tag_array;
  logic [15:0] memory_address, fill_address, fill_data;

  int vectors     = 0;
  int miscompares = 0;

  logic [15:0] wdata [8];
  logic [15:0] obs_rd_addr[$];
  logic [15:0] obs_wr_addr[$];
  logic [15:0] obs_wr_dat[$];
  int          obs_rd_cyc[$];
  int          obs_tag_n, obs_tag_cyc, obs_busy_n, obs_first_busy, obs_last_valid;

  cache_fill_fsm #(.WORDS(8), .AW(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .miss_detected(miss_detected), .miss_address(miss_address),
    .memory_data_valid(memory_data_valid), .memory_data(memory_data),
    .fsm_busy(fsm_busy), .mem_read_req(mem_read_req), .memory_address(memory_address),
    .write_data_array(write_data_array), .fill_address(fill_address), .fill_data(fill_data),
    .write_tag_array(write_tag_array)
  );

  always #5 clk = ~clk;

  // Presents one miss at cycle 0 and plays memory: each request returns wdata for its word 4 cycles later,
  // with at least `gap` idle cycles between valids. Records everything the DUT does until fsm_busy drops.
  task automatic run_fill(input logic [15:0] addr, input int gap, input bit hold_miss);
    int          pend_cyc[$];
    logic [15:0] pend_dat[$];
    logic [15:0] base;
    int          cyc;
    bit          done;
    base = {addr[15:4], 4'h0};
    obs_rd_addr.delete(); obs_rd_cyc.delete(); obs_wr_addr.delete(); obs_wr_dat.delete();
    obs_tag_n = 0; obs_tag_cyc = -1; obs_busy_n = 0; obs_first_busy = -1; obs_last_valid = -100;
    cyc = 0; done = 1'b0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      miss_detected = (cyc == 0) || (hold_miss && obs_tag_n == 0);
      miss_address  = (cyc == 0) ? addr : (addr ^ 16'h0450);
      if (pend_cyc.size() > 0 && cyc >= pend_cyc[0] + 4 && cyc - obs_last_valid > gap) begin
        memory_data_valid = 1'b1;
        memory_data       = pend_dat.pop_front();
        void'(pend_cyc.pop_front());
        obs_last_valid    = cyc;
      end else begin
        memory_data_valid = 1'b0;
        memory_data       = 16'($urandom);
      end
      #1;
      if (mem_read_req) begin
        obs_rd_addr.push_back(memory_address);
        obs_rd_cyc.push_back(cyc);
        pend_cyc.push_back(cyc);
        pend_dat.push_back((memory_address[15:4] == base[15:4]) ? wdata[memory_address[3:1]] : 16'hDEAD);
      end
      if (write_data_array) begin
        obs_wr_addr.push_back(fill_address);
        obs_wr_dat.push_back(fill_data);
      end
      if (write_tag_array) begin
        obs_tag_n++;
        obs_tag_cyc = cyc;
      end
      if (fsm_busy) begin
        obs_busy_n++;
        if (obs_first_busy < 0) obs_first_busy = cyc;
      end
      if (obs_first_busy >= 0 && !fsm_busy) done = 1'b1;
      cyc++;
    end
    miss_detected     = 1'b0;
    memory_data_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    memory_data_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    vectors++;
    if ({fsm_busy, mem_read_req, write_data_array, write_tag_array, memory_address, fill_address} !== '0)
      begin miscompares++; $display("FAIL reset_outputs: busy=%b req=%b wr=%b tag=%b maddr=%h faddr=%h, expected all 0",
        fsm_busy, mem_read_req, write_data_array, write_tag_array, memory_address, fill_address); end
    rst_n = 1'b1;
    memory_data_valid = 1'b0;
  endtask

  task automatic test_basic();
    for (int i = 0; i < 8; i++) wdata[i] = 16'hA000 + 16'(i);
    run_fill(16'h1236, 0, 1'b0);
    vectors++;
    if (obs_rd_addr.size() != 8 || obs_wr_addr.size() != 8)
      begin miscompares++; $display("FAIL basic_counts: reads=%0d writes=%0d, expected 8 and 8", obs_rd_addr.size(), obs_wr_addr.size()); end
    for (int i = 0; i < 8 && i < obs_rd_addr.size(); i++) begin
      vectors++;
      if (obs_rd_addr[i] !== 16'h1230 + 16'(2 * i) || obs_rd_cyc[i] != i + 1)
        begin miscompares++; $display("FAIL basic_read%0d: addr=%h cyc=%0d, expected addr=%h cyc=%0d",
          i, obs_rd_addr[i], obs_rd_cyc[i], 16'h1230 + 16'(2 * i), i + 1); end
    end
    for (int i = 0; i < 8 && i < obs_wr_addr.size(); i++) begin
      vectors++;
      if (obs_wr_addr[i] !== 16'h1230 + 16'(2 * i) || obs_wr_dat[i] !== 16'hA000 + 16'(i))
        begin miscompares++; $display("FAIL basic_write%0d: addr=%h data=%h, expected addr=%h data=%h",
          i, obs_wr_addr[i], obs_wr_dat[i], 16'h1230 + 16'(2 * i), 16'hA000 + 16'(i)); end
    end
    vectors++;
    if (obs_tag_n != 1 || obs_tag_cyc != 13)
      begin miscompares++; $display("FAIL basic_tag: pulses=%0d cycle=%0d, expected 1 pulse at cycle 13", obs_tag_n, obs_tag_cyc); end
    vectors++;
    if (obs_busy_n != 13 || obs_first_busy != 1)
      begin miscompares++; $display("FAIL basic_busy: cycles=%0d first=%0d, expected 13 from cycle 1", obs_busy_n, obs_first_busy); end
  endtask

  task automatic test_reset_midfill();
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      miss_detected     = (c == 0);
      miss_address      = 16'h2468;
      rst_n             = (c != 3);
      memory_data_valid = (c >= 4);
      memory_data       = 16'($urandom);
      #1;
      if (c == 2) begin
        vectors++;
        if (fsm_busy !== 1'b1 || mem_read_req !== 1'b1)
          begin miscompares++; $display("FAIL midfill_running: busy=%b req=%b, expected 1 1", fsm_busy, mem_read_req); end
      end
      if (c == 4) begin
        vectors++;
        if ({fsm_busy, mem_read_req, write_tag_array, memory_address, fill_address} !== '0)
          begin miscompares++; $display("FAIL midfill_reset: busy=%b req=%b tag=%b maddr=%h faddr=%h, expected all 0",
            fsm_busy, mem_read_req, write_tag_array, memory_address, fill_address); end
      end
      if (c >= 4) begin
        vectors++;
        if (write_data_array !== 1'b0 || write_tag_array !== 1'b0 || fsm_busy !== 1'b0)
          begin miscompares++; $display("FAIL midfill_after%0d: wr=%b tag=%b busy=%b, expected 0 0 0",
            c, write_data_array, write_tag_array, fsm_busy); end
      end
    end
    miss_detected = 1'b0; memory_data_valid = 1'b0;
  endtask

  task automatic test_gaps();
    logic [15:0] addr, base;
    addr = 16'($urandom);
    base = {addr[15:4], 4'h0};
    for (int i = 0; i < 8; i++) wdata[i] = 16'($urandom);
    run_fill(addr, 2, 1'b0);
    vectors++;
    if (obs_wr_addr.size() != 8)
      begin miscompares++; $display("FAIL gaps_count: writes=%0d, expected 8", obs_wr_addr.size()); end
    for (int i = 0; i < 8 && i < obs_wr_addr.size(); i++) begin
      vectors++;
      if (obs_wr_addr[i] !== base + 16'(2 * i) || obs_wr_dat[i] !== wdata[i])
        begin miscompares++; $display("FAIL gaps_write%0d: addr=%h data=%h, expected addr=%h data=%h",
          i, obs_wr_addr[i], obs_wr_dat[i], base + 16'(2 * i), wdata[i]); end
    end
    // Valids land at 5, 8, ..., 26, so the tag follows at 27.
    vectors++;
    if (obs_tag_n != 1 || obs_tag_cyc != obs_last_valid + 1 || obs_tag_cyc != 5 + 7 * 3 + 1)
      begin miscompares++; $display("FAIL gaps_tag: pulses=%0d cycle=%0d last_valid=%0d, expected 1 pulse at cycle 27",
        obs_tag_n, obs_tag_cyc, obs_last_valid); end
    vectors++;
    if (obs_busy_n != 27)
      begin miscompares++; $display("FAIL gaps_busy: cycles=%0d, expected 27", obs_busy_n); end
  endtask

  task automatic test_hold_miss();
    logic [15:0] addr, base;
    addr = 16'($urandom);
    base = {addr[15:4], 4'h0};
    for (int i = 0; i < 8; i++) wdata[i] = 16'($urandom);
    run_fill(addr, 0, 1'b1);
    vectors++;
    if (obs_rd_addr.size() != 8 || obs_wr_addr.size() != 8)
      begin miscompares++; $display("FAIL hold_counts: reads=%0d writes=%0d, expected 8 and 8", obs_rd_addr.size(), obs_wr_addr.size()); end
    for (int i = 0; i < 8 && i < obs_wr_addr.size() && i < obs_rd_addr.size(); i++) begin
      vectors++;
      if (obs_rd_addr[i] !== base + 16'(2 * i) || obs_wr_addr[i] !== base + 16'(2 * i) || obs_wr_dat[i] !== wdata[i])
        begin miscompares++; $display("FAIL hold_word%0d: rd=%h wr=%h data=%h, expected addr=%h data=%h",
          i, obs_rd_addr[i], obs_wr_addr[i], obs_wr_dat[i], base + 16'(2 * i), wdata[i]); end
    end
    vectors++;
    if (obs_tag_n != 1 || obs_busy_n != 13)
      begin miscompares++; $display("FAIL hold_restart: pulses=%0d busy=%0d, expected 1 and 13", obs_tag_n, obs_busy_n); end
  endtask

  task automatic test_stray_valid();
    logic [15:0] addr, base;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      memory_data_valid = 1'b1;
      memory_data       = 16'($urandom);
      #1;
      vectors++;
      if (write_data_array !== 1'b0 || fsm_busy !== 1'b0)
        begin miscompares++; $display("FAIL stray_idle%0d: wr=%b busy=%b, expected 0 0", c, write_data_array, fsm_busy); end
    end
    memory_data_valid = 1'b0;
    addr = 16'($urandom);
    base = {addr[15:4], 4'h0};
    for (int i = 0; i < 8; i++) wdata[i] = 16'($urandom);
    run_fill(addr, 0, 1'b0);
    vectors++;
    if (obs_wr_addr.size() != 8)
      begin miscompares++; $display("FAIL stray_count: writes=%0d, expected 8", obs_wr_addr.size()); end
    for (int i = 0; i < 8 && i < obs_wr_addr.size(); i++) begin
      vectors++;
      if (obs_wr_addr[i] !== base + 16'(2 * i) || obs_wr_dat[i] !== wdata[i])
        begin miscompares++; $display("FAIL stray_write%0d: addr=%h data=%h, expected addr=%h data=%h",
          i, obs_wr_addr[i], obs_wr_dat[i], base + 16'(2 * i), wdata[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] bases [2];
    int          tags;
    bases[0] = 16'hFFF0;
    bases[1] = 16'h0000;
    tags = 0;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 8; i++) wdata[i] = 16'($urandom);
      run_fill(bases[f], 0, 1'b0);
      tags += obs_tag_n;
      vectors++;
      if (obs_rd_addr.size() != 8 || obs_wr_addr.size() != 8)
        begin miscompares++; $display("FAIL b2b%0d_counts: reads=%0d writes=%0d, expected 8 and 8", f, obs_rd_addr.size(), obs_wr_addr.size()); end
      for (int i = 0; i < 8 && i < obs_wr_addr.size() && i < obs_rd_addr.size(); i++) begin
        vectors++;
        if (obs_rd_addr[i] !== bases[f] + 16'(2 * i) || obs_wr_addr[i] !== bases[f] + 16'(2 * i) || obs_wr_dat[i] !== wdata[i])
          begin miscompares++; $display("FAIL b2b%0d_word%0d: rd=%h wr=%h data=%h, expected addr=%h data=%h",
            f, i, obs_rd_addr[i], obs_wr_addr[i], obs_wr_dat[i], bases[f] + 16'(2 * i), wdata[i]); end
      end
    end
    vectors++;
    if (tags != 2)
      begin miscompares++; $display("FAIL b2b_tags: pulses=%0d, expected 2", tags); end
  endtask

  task automatic test_random();
    logic [15:0] addr, base;
    int          gap;
    for (int n = 0; n < 6; n++) begin
      addr = 16'($urandom);
      base = {addr[15:4], 4'h0};
      gap  = $urandom_range(0, 2);
      for (int i = 0; i < 8; i++) wdata[i] = 16'($urandom);
      run_fill(addr, gap, 1'b0);
      vectors++;
      if (obs_wr_addr.size() != 8 || obs_rd_addr.size() != 8)
        begin miscompares++; $display("FAIL rand%0d_counts: reads=%0d writes=%0d, expected 8 and 8", n, obs_rd_addr.size(), obs_wr_addr.size()); end
      for (int i = 0; i < 8 && i < obs_wr_addr.size(); i++) begin
        vectors++;
        if (obs_wr_addr[i] !== base + 16'(2 * i) || obs_wr_dat[i] !== wdata[i])
          begin miscompares++; $display("FAIL rand%0d_write%0d: addr=%h data=%h, expected addr=%h data=%h",
            n, i, obs_wr_addr[i], obs_wr_dat[i], base + 16'(2 * i), wdata[i]); end
      end
      vectors++;
      if (obs_tag_n != 1 || obs_tag_cyc != 5 + 7 * (gap + 1) + 1 || obs_busy_n != obs_tag_cyc)
        begin miscompares++; $display("FAIL rand%0d_tag: pulses=%0d cycle=%0d busy=%0d, expected 1 pulse at %0d",
          n, obs_tag_n, obs_tag_cyc, obs_busy_n, 5 + 7 * (gap + 1) + 1); end
    end
  endtask

  initial begin
    rst_n = 1'b0; miss_detected = 1'b0; miss_address = '0;
    memory_data_valid = 1'b0; memory_data = '0;
    test_reset();
    test_basic();
    test_reset_midfill();
    test_gaps();
    test_hold_miss();
    test_stray_valid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
